td4_ctrl_seq: RTL and testbench

- Parametrised control sequencer for the 4-bit TD4-class CPU. It replaces the purely combinational opcode decoder.
- Decodes the ROM opcode into register load strobes and the ALU input-select. It also owns the carry and zero flag registers.
- Adds valid/ready handshakes on IN/OUT with an optional timeout, a JZ instruction and a HALT state.
- Sits between program ROM/PC and the register file/ALU/IO ports.

---
 rtl/td4_ctrl_seq_if.sv | 31 +++
 rtl/td4_ctrl_seq.sv | 161 ++++++++++++++++
 tb/tb_td4_ctrl_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/td4_ctrl_seq_if.sv
// Control bus between the TD4 sequencer and the ROM/PC, ALU, register file and IO ports.
interface td4_ctrl_seq_if;
  logic [3:0] op;
  logic       alu_carry;
  logic       alu_zero;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] load;
  logic [1:0] select;
  logic       pc_inc;
  logic       carry_flag;
  logic       zero_flag;
  logic       halted;
  logic       io_err;

  // Sequencer side.
  modport master (
    input  op, alu_carry, alu_zero, in_valid, out_ready,
    output in_ready, out_valid, load, select, pc_inc,
    output carry_flag, zero_flag, halted, io_err
  );

  // Datapath / IO side.
  modport slave (
    output op, alu_carry, alu_zero, in_valid, out_ready,
    input  in_ready, out_valid, load, select, pc_inc,
    input  carry_flag, zero_flag, halted, io_err
  );
endinterface

// File: rtl/td4_ctrl_seq.sv
// TD4 control sequencer: opcode decode, carry/zero flags, IN/OUT handshakes
// with optional timeout, JZ and HALT.
module td4_ctrl_seq #(
  parameter bit          HANDSHAKE_EN = 1'b1,
  parameter int unsigned TIMEOUT      = 0,
  parameter int unsigned TIMEOUT_W    = 8,
  parameter bit          JZ_EN        = 1'b1,
  parameter bit          HALT_EN      = 1'b1
) (
  input logic            CLK,
  input logic            N_RESET,
  td4_ctrl_seq_if.master bus
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_IO, S_HALT} state_t;

  // Stall limit compared against the incremented wait count; TIMEOUT=1 times
  // out on the first wait cycle.
  localparam int unsigned TO_LIM = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  logic [3:0]           ld_dec;
  logic [1:0]           sel_dec;
  logic                 is_in, is_out, is_nop, is_halt;
  logic [TIMEOUT_W:0]   cnt_inc;
  logic                 to_hit, hs_ok;

  logic [3:0]           load_c;
  logic [1:0]           select_c;
  logic                 pc_inc_c, in_ready_c, out_valid_c;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign to_hit  = (TIMEOUT != 0) && (cnt_inc >= (TIMEOUT_W+1)'(TO_LIM));

  // Opcode decode: load target, ALU source and instruction class.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    ld_dec  = 4'b0000;
    sel_dec = 2'b11;
    is_in   = 1'b0;
    is_out  = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    unique case (bus.op)
      4'b0000: begin ld_dec = 4'b0001; sel_dec = 2'b00; end
      4'b0101: begin ld_dec = 4'b0010; sel_dec = 2'b01; end
      4'b0011: begin ld_dec = 4'b0001; sel_dec = 2'b11; end
      4'b0111: begin ld_dec = 4'b0010; sel_dec = 2'b11; end
      4'b0001: begin ld_dec = 4'b0001; sel_dec = 2'b01; end
      4'b0100: begin ld_dec = 4'b0010; sel_dec = 2'b00; end
      4'b0010: begin ld_dec = 4'b0001; sel_dec = 2'b10; is_in  = 1'b1; end
      4'b0110: begin ld_dec = 4'b0010; sel_dec = 2'b10; is_in  = 1'b1; end
      4'b1001: begin ld_dec = 4'b0100; sel_dec = 2'b01; is_out = 1'b1; end
      4'b1011: begin ld_dec = 4'b0100; sel_dec = 2'b11; is_out = 1'b1; end
      4'b1111: ld_dec = 4'b1000;
      4'b1110: ld_dec = {~carry_q, 3'b000};
      4'b1010: begin
        if (JZ_EN) ld_dec = {zero_q, 3'b000};
        else       is_nop = 1'b1;
      end
      4'b1000: begin
        if (HALT_EN) is_halt = 1'b1;
        else         is_nop  = 1'b1;
      end
      default: is_nop = 1'b1;
    endcase
  end

  // Handshake completion for the current opcode; non-IO ops never wait.
  always_comb begin
    hs_ok = 1'b1;
    if (HANDSHAKE_EN) begin
      if (is_in)       hs_ok = bus.in_valid;
      else if (is_out) hs_ok = bus.out_ready;
    end
  end

  // Next state, flag updates and strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    load_c      = 4'b0000;
    select_c    = 2'b00;
    pc_inc_c    = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state_q)
      S_RUN, S_WAIT_IO: begin
        select_c    = sel_dec;
        in_ready_c  = is_in;
        out_valid_c = is_out;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (hs_ok) begin
          load_c   = ld_dec;
          pc_inc_c = ~ld_dec[3];
          state_d  = S_RUN;
          if (!is_nop) begin
            carry_d = bus.alu_carry;
            zero_d  = bus.alu_zero;
          end
        end else if (state_q == S_RUN) begin
          state_d = S_WAIT_IO;
          cnt_d   = '0;
        end else if (to_hit) begin
          pc_inc_c = 1'b1;
          err_d    = 1'b1;
          state_d  = S_RUN;
        end else begin
          cnt_d = cnt_inc[TIMEOUT_W-1:0];
        end
      end
      default: ;
    endcase
    // Reset silences every strobe immediately, not just at the next edge.
    if (!N_RESET) begin
      load_c      = 4'b0000;
      select_c    = 2'b00;
      pc_inc_c    = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
    end
  end

  // State, wait counter and flag registers.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.load       = load_c;
  assign bus.select     = select_c;
  assign bus.pc_inc     = pc_inc_c;
  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.io_err     = err_q;
  assign bus.halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_td4_ctrl_seq.sv
// Scoreboard bench for td4_ctrl_seq: dut0 uses defaults, dut1 has TIMEOUT=4
// with JZ and HALT disabled.
module tb_td4_ctrl_seq;

  logic CLK = 1'b0;
  logic N_RESET = 1'b0;
  always #5 CLK = ~CLK;

  logic [3:0] op_s = 4'b0000;
  logic       c_s = 1'b0, z_s = 1'b0, iv_s = 1'b0, or_s = 1'b0;

  td4_ctrl_seq_if b0 ();
  td4_ctrl_seq_if b1 ();

  assign b0.op = op_s;  assign b0.alu_carry = c_s;  assign b0.alu_zero = z_s;
  assign b0.in_valid = iv_s;  assign b0.out_ready = or_s;
  assign b1.op = op_s;  assign b1.alu_carry = c_s;  assign b1.alu_zero = z_s;
  assign b1.in_valid = iv_s;  assign b1.out_ready = or_s;

  td4_ctrl_seq dut0 (.CLK(CLK), .N_RESET(N_RESET), .bus(b0));
  td4_ctrl_seq #(.TIMEOUT(4), .JZ_EN(1'b0), .HALT_EN(1'b0))
    dut1 (.CLK(CLK), .N_RESET(N_RESET), .bus(b1));

  // Observed vector: {load, select, pc_inc, in_ready, out_valid, halted, carry, zero, io_err}
  typedef struct {
    string       tag;
    int          d;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [12:0] e(input logic [3:0] ld, input logic [1:0] sel,
                                    input logic pc, ir, ov, h, cf, zf, er);
    return {ld, sel, pc, ir, ov, h, cf, zf, er};
  endfunction

  function automatic logic [12:0] obs(input int d);
    if (d == 0)
      return {b0.load, b0.select, b0.pc_inc, b0.in_ready, b0.out_valid,
              b0.halted, b0.carry_flag, b0.zero_flag, b0.io_err};
    return {b1.load, b1.select, b1.pc_inc, b1.in_ready, b1.out_valid,
            b1.halted, b1.carry_flag, b1.zero_flag, b1.io_err};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got ld/sel/pc/ir/ov/h/c/z/err=%b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the negedge.
  task automatic step(input string tag, input int d, input logic [3:0] op,
                      input logic c, z, iv, ordy, input logic [12:0] exp);
    exp_t x;
    op_s = op; c_s = c; z_s = z; iv_s = iv; or_s = ordy;
    sb.push_back('{tag, d, exp});
    @(negedge CLK);
    x = sb.pop_front();
    check(x.tag, obs(x.d), x.v);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int d);
    N_RESET = 1'b0;
    step($sformatf("reset%0d", d), d, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1,
         e(4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    N_RESET = 1'b1;
  endtask

  initial begin
    @(posedge CLK); #1;

    // ---------------- dut0: defaults ----------------
    do_reset(0);
    step("mov_a_im", 0, 4'b0011, 0, 0, 0, 0, e(4'b0001, 2'b11, 1, 0, 0, 0, 0, 0, 0));
    step("add_a_c1", 0, 4'b0000, 1, 0, 0, 0, e(4'b0001, 2'b00, 1, 0, 0, 0, 0, 0, 0));
    step("jnc_notk", 0, 4'b1110, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 1, 0, 0));
    step("jnc_take", 0, 4'b1110, 0, 0, 0, 0, e(4'b1000, 2'b11, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("in_stall%0d", i), 0, 4'b0010, 0, 1, 0, 0,
           e(4'b0000, 2'b10, 0, 1, 0, 0, 0, 0, 0));
    step("in_retire", 0, 4'b0010, 0, 1, 1, 0, e(4'b0001, 2'b10, 1, 1, 0, 0, 0, 0, 0));
    step("jz_take",   0, 4'b1010, 0, 0, 0, 0, e(4'b1000, 2'b11, 0, 0, 0, 0, 0, 1, 0));
    step("jz_notk",   0, 4'b1010, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0));
    step("out_b",     0, 4'b1001, 0, 0, 0, 1, e(4'b0100, 2'b01, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      step($sformatf("out_stall%0d", i), 0, 4'b1011, 1, 1, 0, 0,
           e(4'b0000, 2'b11, 0, 0, 1, 0, 0, 0, 0));
    step("out_retire", 0, 4'b1011, 0, 0, 0, 1, e(4'b0100, 2'b11, 1, 0, 1, 0, 0, 0, 0));
    step("add_b_c1z1", 0, 4'b0101, 1, 1, 0, 0, e(4'b0010, 2'b01, 1, 0, 0, 0, 0, 0, 0));
    step("nop_hold",  0, 4'b1100, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 1, 1, 0));
    step("halt_ret",  0, 4'b1000, 0, 0, 0, 0, e(4'b0000, 2'b11, 0, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 10; i++) begin
      logic [3:0] hop;
      hop = 4'(i + 1);
      step($sformatf("halted%0d", i), 0, hop, 0, 0, 1, 1,
           e(4'b0000, 2'b00, 0, 0, 0, 1, 1, 1, 0));
    end
    do_reset(0);
    step("post_halt", 0, 4'b0011, 0, 0, 0, 0, e(4'b0001, 2'b11, 1, 0, 0, 0, 0, 0, 0));

    // ---------------- dut1: TIMEOUT=4, JZ/HALT off ----------------
    do_reset(1);
    for (int i = 0; i < 3; i++)
      step($sformatf("to_stall%0d", i), 1, 4'b1001, 1, 1, 0, 0,
           e(4'b0000, 2'b01, 0, 0, 1, 0, 0, 0, 0));
    step("to_nop",    1, 4'b1001, 1, 1, 0, 0, e(4'b0000, 2'b01, 1, 0, 1, 0, 0, 0, 0));
    step("err_set",   1, 4'b0011, 0, 1, 0, 0, e(4'b0001, 2'b11, 1, 0, 0, 0, 0, 0, 1));
    step("jz_as_nop", 1, 4'b1010, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 0, 1, 1));
    step("halt_nop",  1, 4'b1000, 1, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 0, 1, 1));
    step("mov_a_b",   1, 4'b0001, 0, 0, 0, 0, e(4'b0001, 2'b01, 1, 0, 0, 0, 0, 1, 1));
    step("err_stick", 1, 4'b1100, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 1));
    do_reset(1);
    step("err_clr",   1, 4'b1100, 0, 0, 0, 0, e(4'b0000, 2'b11, 1, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
